rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised, registered N-to-1 datapath multiplexer. Generalises the fixed 8:1 32-bit select mux in both width and channel count.
- Replaces the external select lines with internal round-robin arbitration and per-channel valid/ready handshakes.
- Sits between multiple datapath producers (ALU, load unit, immediate path, forwarding sources) and a single consumer, such as the register-file write port.
- One output register stage: every accepted beat appears one cycle after acceptance.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_CH, 8, number of input channels (2..16).
- SEL_W, 3, width of the channel index; must equal clog2(NUM_CH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_last  input  NUM_CH  per-channel end-of-burst marker; used only with ARB_MUX_LOCK_EN.
- in_ready  output  NUM_CH  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_ch hold a valid beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr pointer=NUM_CH-1 (so channel 0 has first priority), lock flag=0.
- load_en = !out_valid || out_ready. Full throughput: one beat per cycle when the consumer is always ready.
- Arbitration is combinational each cycle. Search starts at (ptr+1) mod NUM_CH and wraps. The first channel with in_valid=1 is granted.
- in_ready[g] = load_en && any_valid. All other in_ready bits = 0. in_ready is never asserted when no channel is valid.
- Transfer on channel g when in_valid[g] && in_ready[g]. On the next clock edge:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1, ptr <= g.
- If load_en=1 and no channel is valid: out_valid <= 0 on the next edge, and out_data/out_ch hold their last values.
- Stall: if out_valid && !out_ready, out_data/out_ch/out_valid hold, all in_ready=0, and ptr holds.
- Simultaneous drain and load: the same cycle the consumer takes a beat, a new beat is loaded. There is no bubble.
- Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NUM_CH-1,0...
- Wrap-around: when ptr=NUM_CH-1 the search starts at 0. When ptr=g and only g is valid, g is granted again.
- Reset mid-operation: any held beat is discarded and out_valid drops immediately (asynchronously). Arbitration restarts from channel 0.
- in_data of non-granted channels has no effect. Producers must hold data/valid until ready (standard valid/ready rule). The block does not check this.
- Latency: input transfer to out_valid is 1 cycle. There is no combinational path from in_data to out_data.

Optional Feature:
- Macro ARB_MUX_LOCK_EN.
- Defined:
  - A transfer with in_last[g]=0 sets lock=1 with locked channel g.
  - While lock=1, only channel g may be granted, even if other channels are valid. Idle cycles on g keep the lock.
  - A transfer with in_last[g]=1 clears lock, and ptr advances normally.
  - Reset clears lock.
- Undefined: in_last is ignored, there is no lock state, and every beat is arbitrated independently.

Test Plan:
- Reset, then ch0=0x11111111, ch5=0x55555555 both valid, out_ready=1. Expected:
  - cycle 1: out_ch=0, out_data=0x11111111
  - cycle 2: out_ch=5, out_data=0x55555555
  - cycle 3: out_valid=0
- All 8 channels valid continuously with data=0xA0+i, out_ready=1 for 16 cycles -> out_ch sequence 0..7,0..7 back-to-back, with no out_valid gap.
- Beat from ch3 held with out_ready=0 for 4 cycles while ch2 is valid -> out_data stays at ch3 value, in_ready=0x00 throughout; after out_ready=1, ch2 is granted (wrap 3->...->2) in the same cycle.
- Assert rst_n=0 mid-stream while out_valid=1 -> out_valid=0 without a clock edge; after release, the first grant goes to the lowest valid index.
- ARB_MUX_LOCK_EN: ch1 sends 3 beats (in_last=0,0,1) while ch4 is continuously valid -> out_ch=1,1,1 then 4; the same stimulus without the macro gives out_ch=1,4,1,4.
- WIDTH=16, NUM_CH=4, SEL_W=2 instance: only ch3 valid with 0xBEEF on every cycle -> out_ch=3, out_data=0xBEEF every cycle, ptr wrap 3->3.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux -- registered N:1 datapath mux with round-robin arbitration.
//
// Collects beats from NUM_CH valid/ready producers and presents one beat per
// cycle to a single consumer through one output register stage. The channel
// search starts one past the last granted channel and wraps, so grants rotate
// fairly when every channel is busy. A beat is accepted in the same cycle the
// consumer drains the previous one, so there are no bubbles.
//
// Optional feature (macro ARB_MUX_LOCK_EN): burst lock. A beat accepted with
// in_last=0 locks arbitration onto its channel until a beat with in_last=1 is
// accepted. Without the macro in_last is ignored.
//
// Parameters:
//   WIDTH  data width per channel
//   NUM_CH number of input channels (2..16)
//   SEL_W  channel index width, must equal $clog2(NUM_CH)
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   in_data     channel i data at [i*WIDTH +: WIDTH]
//   in_valid    per-channel valid
//   in_last     per-channel end-of-burst marker (lock build only)
//   in_ready    per-channel ready, one-hot or zero
//   out_data    registered data of the accepted beat
//   out_ch      index of the channel that produced out_data
//   out_valid   out_data/out_ch hold a beat
//   out_ready   consumer accepts the beat

// Per-channel request masking and ready generation.
module rr_arb_mux_lane #(
  parameter int SEL_W = 3,
  parameter int IDX   = 0
) (
  input  logic             valid,
  input  logic             lock,
  input  logic [SEL_W-1:0] ptr,
  input  logic             gnt_found,
  input  logic [SEL_W-1:0] gnt_idx,
  input  logic             load_en,
  output logic             req,
  output logic             ready
);
  logic own;

  // While locked, ptr is the locked channel: only it may request.
  assign own   = (ptr == SEL_W'(IDX));
  assign req   = valid && (!lock || own);
  assign ready = load_en && gnt_found && (gnt_idx == SEL_W'(IDX));
endmodule

module rr_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic [STAGES:0]    vld_pipe;
  beat_t              out_q;
  beat_t              beat_d;
  logic [SEL_W-1:0]   ptr_q;
  logic               lock;
  logic [NUM_CH-1:0]  req;
  logic               gnt_found;
  logic [SEL_W-1:0]   gnt_idx;
  logic               load_en;
  logic               xfer;

  // Output register can take a new beat when empty or being drained.
  assign load_en = !vld_pipe[STAGES] || out_ready;
  assign xfer    = load_en && gnt_found;

  // Per-channel lanes.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    rr_arb_mux_lane #(
      .SEL_W (SEL_W),
      .IDX   (i)
    ) u_lane (
      .valid     (in_valid[i]),
      .lock      (lock),
      .ptr       (ptr_q),
      .gnt_found (gnt_found),
      .gnt_idx   (gnt_idx),
      .load_en   (load_en),
      .req       (req[i]),
      .ready     (in_ready[i])
    );
  end

  // Round-robin search from ptr+1, wrapping; first requester wins.
  // Offset NUM_CH lands back on ptr itself, so a lone repeat requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!gnt_found && req[(int'(ptr_q) + k) % NUM_CH]) begin
        gnt_found = 1'b1;
        gnt_idx   = SEL_W'((int'(ptr_q) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    beat_d.ch   = gnt_idx;
    beat_d.data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
  end

  always_comb vld_pipe[0] = gnt_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      out_q              <= '0;
      ptr_q              <= SEL_W'(NUM_CH - 1);
    end else if (load_en) begin
      vld_pipe[1] <= vld_pipe[0];
      if (xfer) begin
        out_q <= beat_d;
        ptr_q <= gnt_idx;
      end
    end
  end

`ifdef ARB_MUX_LOCK_EN
  logic lock_q;

  // Locked channel is always ptr_q, since the lock is taken on its transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lock_q <= 1'b0;
    else if (xfer) lock_q <= !in_last[gnt_idx];
  end

  assign lock = lock_q;
`else
  logic unused_in_last;

  assign lock           = 1'b0;
  assign unused_in_last = ^in_last;
`endif

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = out_q.data;
  assign out_ch    = out_q.ch;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: default 8x32 instance plus a 4x16 instance.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0][31:0] dat;
  logic [7:0]       vld, last, rdy;
  logic [31:0]      odata;
  logic [2:0]       och;
  logic             ovld, ordy;

  logic [3:0][15:0] s_dat;
  logic [3:0]       s_vld, s_last, s_rdy;
  logic [15:0]      s_odata;
  logic [1:0]       s_och;
  logic             s_ovld, s_ordy;

  int errors = 0;
  int checks = 0;

  rr_arb_mux u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (dat),
    .in_valid  (vld),
    .in_last   (last),
    .in_ready  (rdy),
    .out_data  (odata),
    .out_ch    (och),
    .out_valid (ovld),
    .out_ready (ordy)
  );

  rr_arb_mux #(.WIDTH(16), .NUM_CH(4), .SEL_W(2)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (s_dat),
    .in_valid  (s_vld),
    .in_last   (s_last),
    .in_ready  (s_rdy),
    .out_data  (s_odata),
    .out_ch    (s_och),
    .out_valid (s_ovld),
    .out_ready (s_ordy)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    vld = '0; last = '0; ordy = 1'b1;
    s_vld = '0; s_last = '0; s_ordy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dat = '0; vld = '0; last = '0; ordy = 1'b1;
    s_dat = '0; s_vld = '0; s_last = '0; s_ordy = 1'b1;
    #2;
    checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ovld); end
    checks++; if (odata !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", odata); end
    checks++; if (och !== 3'd0) begin errors++; $display("FAIL reset_out_ch got=%0d exp=0", och); end
    checks++; if (rdy !== 8'h00) begin errors++; $display("FAIL reset_in_ready got=%h exp=00", rdy); end
    checks++; if (s_ovld !== 1'b0) begin errors++; $display("FAIL reset_small_valid got=%b exp=0", s_ovld); end
    checks++; if (s_odata !== 16'h0) begin errors++; $display("FAIL reset_small_data got=%h exp=0", s_odata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL idle_out_valid got=%b exp=0", ovld); end
  endtask

  task automatic test_basic();
    do_reset();
    dat[0] = 32'h11111111; dat[5] = 32'h55555555; vld = 8'h21;
    #1;
    checks++; if (rdy !== 8'h01) begin errors++; $display("FAIL basic_ready0 got=%h exp=01", rdy); end
    @(posedge clk); #1;
    checks++; if (ovld !== 1'b1) begin errors++; $display("FAIL basic_valid1 got=%b exp=1", ovld); end
    checks++; if (och !== 3'd0) begin errors++; $display("FAIL basic_ch1 got=%0d exp=0", och); end
    checks++; if (odata !== 32'h11111111) begin errors++; $display("FAIL basic_data1 got=%h exp=11111111", odata); end
    vld = 8'h20;
    #1;
    checks++; if (rdy !== 8'h20) begin errors++; $display("FAIL basic_ready5 got=%h exp=20", rdy); end
    @(posedge clk); #1;
    checks++; if (och !== 3'd5) begin errors++; $display("FAIL basic_ch2 got=%0d exp=5", och); end
    checks++; if (odata !== 32'h55555555) begin errors++; $display("FAIL basic_data2 got=%h exp=55555555", odata); end
    vld = 8'h00;
    @(posedge clk); #1;
    checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL basic_valid3 got=%b exp=0", ovld); end
    checks++; if (odata !== 32'h55555555) begin errors++; $display("FAIL basic_hold_data got=%h exp=55555555", odata); end
    checks++; if (och !== 3'd5) begin errors++; $display("FAIL basic_hold_ch got=%0d exp=5", och); end
    checks++; if (rdy !== 8'h00) begin errors++; $display("FAIL basic_idle_ready got=%h exp=00", rdy); end
  endtask

  task automatic test_fairness();
    logic [2:0]  exp_ch;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 8; i++) dat[i] = 32'(32'hA0 + i);
    vld = 8'hFF;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      exp_ch = 3'(c % 8);
      exp_d  = 32'(32'hA0 + (c % 8));
      checks++; if (ovld !== 1'b1) begin errors++; $display("FAIL fair_valid c=%0d got=%b exp=1", c, ovld); end
      checks++; if (och !== exp_ch) begin errors++; $display("FAIL fair_ch c=%0d got=%0d exp=%0d", c, och, exp_ch); end
      checks++; if (odata !== exp_d) begin errors++; $display("FAIL fair_data c=%0d got=%h exp=%h", c, odata, exp_d); end
    end
    vld = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    do_reset();
    dat[3] = 32'h33333333; dat[2] = 32'h22222222; vld = 8'h08;
    @(posedge clk); #1;
    checks++; if (och !== 3'd3) begin errors++; $display("FAIL stall_first_ch got=%0d exp=3", och); end
    ordy = 1'b0; vld = 8'h04;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (rdy !== 8'h00) begin errors++; $display("FAIL stall_ready c=%0d got=%h exp=00", c, rdy); end
      checks++; if (odata !== 32'h33333333) begin errors++; $display("FAIL stall_data c=%0d got=%h exp=33333333", c, odata); end
      checks++; if (ovld !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d got=%b exp=1", c, ovld); end
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    #1;
    checks++; if (rdy !== 8'h04) begin errors++; $display("FAIL stall_release_ready got=%h exp=04", rdy); end
    @(posedge clk); #1;
    checks++; if (och !== 3'd2) begin errors++; $display("FAIL stall_next_ch got=%0d exp=2", och); end
    checks++; if (odata !== 32'h22222222) begin errors++; $display("FAIL stall_next_data got=%h exp=22222222", odata); end
    checks++; if (ovld !== 1'b1) begin errors++; $display("FAIL stall_next_valid got=%b exp=1", ovld); end
    vld = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) dat[i] = 32'(32'hA0 + i);
    vld = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (ovld !== 1'b1 || och !== 3'd1) begin errors++; $display("FAIL mid_pre got=%b/%0d exp=1/1", ovld, och); end
    rst_n = 1'b0;
    #2;
    checks++; if (ovld !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%b exp=0", ovld); end
    checks++; if (och !== 3'd0) begin errors++; $display("FAIL mid_async_ch got=%0d exp=0", och); end
    vld = 8'h44;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (och !== 3'd2) begin errors++; $display("FAIL mid_restart_ch got=%0d exp=2", och); end
    checks++; if (odata !== 32'hA2) begin errors++; $display("FAIL mid_restart_data got=%h exp=a2", odata); end
    vld = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    logic [2:0] got [4];
    logic [2:0] exp [4];
    int n, beat;
    logic fired;
`ifdef ARB_MUX_LOCK_EN
    exp[0] = 3'd1; exp[1] = 3'd1; exp[2] = 3'd1; exp[3] = 3'd4;
`else
    exp[0] = 3'd1; exp[1] = 3'd4; exp[2] = 3'd1; exp[3] = 3'd4;
`endif
    do_reset();
    dat[4] = 32'h44444444; dat[1] = 32'h100; last[1] = 1'b0; vld = 8'h12;
    n = 0; beat = 0;
    for (int c = 0; c < 12 && n < 4; c++) begin
      #1;
      fired = rdy[1];
      @(posedge clk); #1;
      if (ovld) begin got[n] = och; n++; end
      if (fired) begin
        beat++;
        if (beat == 3) vld[1] = 1'b0;
        else dat[1] = 32'(32'h100 + beat);
        last[1] = (beat == 2);
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL lock_beats got=%0d exp=4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== exp[k]) begin errors++; $display("FAIL lock_seq k=%0d got=%0d exp=%0d", k, got[k], exp[k]); end
      end
    end
    vld = 8'h00; last = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_small();
    do_reset();
    s_dat[3] = 16'hBEEF; s_vld = 4'h8;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (s_rdy !== 4'h8) begin errors++; $display("FAIL small_ready c=%0d got=%h exp=8", c, s_rdy); end
      @(posedge clk); #1;
      checks++; if (s_ovld !== 1'b1) begin errors++; $display("FAIL small_valid c=%0d got=%b exp=1", c, s_ovld); end
      checks++; if (s_och !== 2'd3) begin errors++; $display("FAIL small_ch c=%0d got=%0d exp=3", c, s_och); end
      checks++; if (s_odata !== 16'hBEEF) begin errors++; $display("FAIL small_data c=%0d got=%h exp=beef", c, s_odata); end
    end
    s_vld = 4'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_stall();
    test_reset_mid();
    test_lock();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
